// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the IF/ID trace buffer.
// Entry layout in the trace RAM, MSB to LSB: {cycle tag, PC+4, instruction, flush flag}.
// Provides the index-width helper and the entry-width helper used by the
// interface, the top level and the RAM.
package mips_trace_buffer_pkg;

  // Bit position of the flush flag; the other fields are stacked above it.
  localparam int unsigned FLUSH_BIT = 0;

  // Width of an index into a DEPTH-entry buffer (never less than one bit).
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned entry_w(input int unsigned cyc_w,
                                          input int unsigned addr_w,
                                          input int unsigned ins_w);
    return cyc_w + addr_w + ins_w + 1;
  endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Bus bundle between the trace buffer and its surroundings.
// Capture side: en, if_id_next_ins_adr, if_id_cur_ins, stall, flush.
// Read side:    rd_req, rd_idx in; rd_valid, rd_err, rd_cycle, rd_pc, rd_ins,
//               rd_flushed out.
// Status:       cycle_count, count, wrapped, done.
// modport master: the core/host side that drives capture and read requests.
// modport slave:  the trace buffer itself.
interface mips_trace_buffer_if
  import mips_trace_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INS_W  = 32,
  parameter int unsigned CYC_W  = 16,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = idx_w(DEPTH);

  logic              en;
  logic [ADDR_W-1:0] if_id_next_ins_adr;
  logic [INS_W-1:0]  if_id_cur_ins;
  logic              stall;
  logic              flush;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic              rd_err;
  logic [CYC_W-1:0]  rd_cycle;
  logic [ADDR_W-1:0] rd_pc;
  logic [INS_W-1:0]  rd_ins;
  logic              rd_flushed;
  logic [CYC_W-1:0]  cycle_count;
  logic [IDX_W:0]    count;
  logic              wrapped;
  logic              done;

  modport master (
    output en, if_id_next_ins_adr, if_id_cur_ins, stall, flush, rd_req, rd_idx,
    input  rd_valid, rd_err, rd_cycle, rd_pc, rd_ins, rd_flushed,
           cycle_count, count, wrapped, done
  );

  modport slave (
    input  en, if_id_next_ins_adr, if_id_cur_ins, stall, flush, rd_req, rd_idx,
    output rd_valid, rd_err, rd_cycle, rd_pc, rd_ins, rd_flushed,
           cycle_count, count, wrapped, done
  );
endinterface

// File: rtl/mips_trace_buffer_trace_ram.sv
// DEPTH x WIDTH simple dual-port RAM: synchronous write, registered read.
// Ports: clk_i, rst_i (clears only the read register), we_i/waddr_i/wdata_i
// write port, re_i/raddr_i read port, rdata_o registered read data.
// The read register only loads when re_i is high, so it holds the last
// returned entry otherwise. A read and write to the same address in one cycle
// returns the old contents.
module mips_trace_buffer_trace_ram
  import mips_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 81
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [idx_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    re_i,
  input  logic [idx_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mips_trace_buffer.sv
// IF/ID trace buffer: captures {cycle, PC+4, instruction, flush} each active,
// unstalled cycle into a circular buffer and serves entries oldest-first over
// a registered read port. Capture halts once the cycle counter reaches
// STOP_CYCLE (0 = never).
// Ports: clk, rst (async, active-high), bus (slave modport of
// mips_trace_buffer_if carrying capture inputs, read port and status).
module mips_trace_buffer
  import mips_trace_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INS_W      = 32,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STOP_CYCLE = 50
) (
  input logic                clk,
  input logic                rst,
  mips_trace_buffer_if.slave bus
);
  localparam int unsigned IDX_W   = idx_w(DEPTH);
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = entry_w(CYC_W, ADDR_W, INS_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CYC_W-1:0] STOP = CYC_W'(STOP_CYCLE);

  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wrapped_q, wrapped_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_err_q, rd_err_d;
  logic               active, cap, rd_hit;
  logic [IDX_W-1:0]   oldest, rd_addr;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  always_comb begin
    active     = bus.en & ~done_q;
    cap        = active & ~bus.stall;   // stall wins over flush
    cyc_d      = cyc_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    done_d     = done_q;
    if (active) begin
      cyc_d = cyc_q + CYC_W'(1);
      if ((STOP_CYCLE != 0) && (cyc_d == STOP)) done_d = 1'b1;
    end
    if (cap) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q == FULL) wrapped_d = 1'b1;
      else count_d = count_q + CNT_W'(1);
    end
    // Reads resolve against the pre-write state: registered pointers/count
    // here, and the RAM returns old contents on a same-cycle write.
    oldest     = (count_q == FULL) ? wr_ptr_q : '0;
    rd_addr    = oldest + bus.rd_idx;   // wraps modulo DEPTH
    rd_hit     = bus.rd_req && ({1'b0, bus.rd_idx} < count_q);
    rd_valid_d = rd_hit;
    rd_err_d   = bus.rd_req & ~rd_hit;
  end

  assign wr_data = {cyc_q, bus.if_id_next_ins_adr, bus.if_id_cur_ins, bus.flush};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  mips_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (cap),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_hit),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_err      = rd_err_q;
  assign bus.rd_cycle    = rd_data[ENTRY_W-1 -: CYC_W];
  assign bus.rd_pc       = rd_data[INS_W+1 +: ADDR_W];
  assign bus.rd_ins      = rd_data[FLUSH_BIT+1 +: INS_W];
  assign bus.rd_flushed  = rd_data[FLUSH_BIT];
  assign bus.cycle_count = cyc_q;
  assign bus.count       = count_q;
  assign bus.wrapped     = wrapped_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_mips_trace_buffer.sv
module tb_mips_trace_buffer;
  localparam int ADDR_W = 32, INS_W = 32, CYC_W = 16, DEPTH = 16, STOP_CYCLE = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_trace_buffer_if #(.ADDR_W(ADDR_W), .INS_W(INS_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) bus();

  mips_trace_buffer #(
    .ADDR_W(ADDR_W), .INS_W(INS_W), .CYC_W(CYC_W), .DEPTH(DEPTH), .STOP_CYCLE(STOP_CYCLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        vld, err;
    logic [15:0] cyc;
    logic [31:0] pc, ins;
    logic        fl;
  } rd_t;

  typedef struct {
    logic [15:0] cyc;
    logic [31:0] pc, ins;
    logic        fl;
  } ent_t;

  typedef struct {
    logic        en, stall, flush;
    logic [31:0] pc;
    logic        rq;
    logic [3:0]  idx;
    logic        e_vld, e_err;
    logic [15:0] e_cyc;
    logic [31:0] e_pc;
    logic [4:0]  e_cnt;
  } vec_t;

  int total = 0;
  int passed = 0;

  // Reference model: list of captured entries, oldest first, capped at DEPTH.
  ent_t        trace[$];
  rd_t         exp_q[$];
  rd_t         m_last;
  logic [15:0] m_cyc;
  logic        m_wrapped, m_done;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    trace.delete();
    exp_q.delete();
    m_cyc = '0;
    m_wrapped = 1'b0;
    m_done = 1'b0;
    m_last = '{default: '0};
  endtask

  task automatic check_all(input rd_t r);
    chk("rd_valid", bus.rd_valid, r.vld);
    chk("rd_err", bus.rd_err, r.err);
    chk("rd_cycle", bus.rd_cycle, r.cyc);
    chk("rd_pc", bus.rd_pc, r.pc);
    chk("rd_ins", bus.rd_ins, r.ins);
    chk("rd_flushed", bus.rd_flushed, r.fl);
    chk("cycle_count", bus.cycle_count, m_cyc);
    chk("count", bus.count, trace.size());
    chk("wrapped", bus.wrapped, m_wrapped);
    chk("done", bus.done, m_done);
  endtask

  task automatic step(input logic e, input logic s, input logic f,
                      input logic [31:0] pc, input logic rq, input logic [3:0] idx);
    rd_t  r;
    ent_t n;
    bus.en = e;
    bus.stall = s;
    bus.flush = f;
    bus.if_id_next_ins_adr = pc;
    bus.if_id_cur_ins = pc ^ 32'hC0DE_0000;
    bus.rd_req = rq;
    bus.rd_idx = idx;
    // Read answer from the state before this edge's capture.
    r = m_last;
    r.vld = 1'b0;
    r.err = 1'b0;
    if (rq) begin
      if (int'(idx) < trace.size()) begin
        r.vld = 1'b1;
        r.cyc = trace[idx].cyc;
        r.pc  = trace[idx].pc;
        r.ins = trace[idx].ins;
        r.fl  = trace[idx].fl;
      end else begin
        r.err = 1'b1;
      end
    end
    m_last = r;
    exp_q.push_back(r);
    if (e && !m_done) begin
      if (!s) begin
        n.cyc = m_cyc;
        n.pc  = pc;
        n.ins = pc ^ 32'hC0DE_0000;
        n.fl  = f;
        trace.push_back(n);
        if (trace.size() > DEPTH) begin
          void'(trace.pop_front());
          m_wrapped = 1'b1;
        end
      end
      m_cyc = m_cyc + 16'd1;
      if (m_cyc == 16'(STOP_CYCLE)) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    check_all(r);
  endtask

  task automatic rd(input logic [3:0] idx);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, idx);
  endtask

  // Asserts reset between clock edges and checks outputs clear immediately.
  task automatic reset_dut();
    rst = 1'b1;
    bus.en = 0; bus.stall = 0; bus.flush = 0; bus.rd_req = 0; bus.rd_idx = '0;
    bus.if_id_next_ins_adr = '0; bus.if_id_cur_ins = '0;
    #1;
    model_reset();
    check_all(m_last);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en st fl pc      rq idx  vld err cyc    pc      cnt
    tv[0]  = '{1, 0, 0, 32'd4,  0, 4'd0, 0, 0, 16'd0, 32'd0,  5'd1};
    tv[1]  = '{1, 0, 0, 32'd8,  0, 4'd0, 0, 0, 16'd0, 32'd0,  5'd2};
    tv[2]  = '{1, 0, 0, 32'd12, 0, 4'd0, 0, 0, 16'd0, 32'd0,  5'd3};
    tv[3]  = '{1, 0, 0, 32'd16, 1, 4'd7, 0, 1, 16'd0, 32'd0,  5'd4};
    tv[4]  = '{1, 0, 0, 32'd20, 0, 4'd0, 0, 0, 16'd0, 32'd0,  5'd5};
    tv[5]  = '{0, 0, 0, 32'd0,  1, 4'd0, 1, 0, 16'd0, 32'd4,  5'd5};
    tv[6]  = '{0, 0, 0, 32'd0,  1, 4'd1, 1, 0, 16'd1, 32'd8,  5'd5};
    tv[7]  = '{0, 0, 0, 32'd0,  1, 4'd2, 1, 0, 16'd2, 32'd12, 5'd5};
    tv[8]  = '{0, 0, 0, 32'd0,  1, 4'd3, 1, 0, 16'd3, 32'd16, 5'd5};
    tv[9]  = '{0, 0, 0, 32'd0,  1, 4'd4, 1, 0, 16'd4, 32'd20, 5'd5};
    tv[10] = '{0, 0, 0, 32'd0,  1, 4'd5, 0, 1, 16'd4, 32'd20, 5'd5};
    tv[11] = '{0, 0, 0, 32'd0,  0, 4'd0, 0, 0, 16'd4, 32'd20, 5'd5};

    // Basic capture and readback, including an out-of-range read.
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      step(tv[i].en, tv[i].stall, tv[i].flush, tv[i].pc, tv[i].rq, tv[i].idx);
      chk("tv_vld", bus.rd_valid, tv[i].e_vld);
      chk("tv_err", bus.rd_err, tv[i].e_err);
      chk("tv_cyc", bus.rd_cycle, tv[i].e_cyc);
      chk("tv_pc", bus.rd_pc, tv[i].e_pc);
      chk("tv_cnt", bus.count, tv[i].e_cnt);
    end

    // Wrap: 20 captures, the last one with a same-edge read of the oldest.
    reset_dut();
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0, 32'(4 * (i + 1)), 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 32'd80, 1'b1, 4'd0);
    chk("same_edge_oldest", bus.rd_cycle, 16'd3);
    chk("wrap_count", bus.count, 5'd16);
    chk("wrap_flag", bus.wrapped, 1'b1);
    rd(4'd0);
    chk("wrap_idx0", bus.rd_cycle, 16'd4);
    rd(4'd15);
    chk("wrap_idx15", bus.rd_cycle, 16'd19);
    chk("wrap_idx15_pc", bus.rd_pc, 32'd80);

    // Stall in cycles 2-3 (cycle 3 also flushes), flush in cycle 5.
    reset_dut();
    for (int c = 0; c < 8; c++)
      step(1'b1, (c == 2 || c == 3), (c == 3 || c == 5), 32'(4 * (c + 1)), 1'b0, 4'd0);
    chk("stall_cycles", bus.cycle_count, 16'd8);
    chk("stall_count", bus.count, 5'd6);
    for (int i = 0; i < 6; i++) begin
      rd(4'(i));
      if (i == 2) chk("stall_idx2", bus.rd_cycle, 16'd4);
      if (i == 3) begin
        chk("flush_idx3_cyc", bus.rd_cycle, 16'd5);
        chk("flush_idx3_flag", bus.rd_flushed, 1'b1);
      end
    end

    // Stop at STOP_CYCLE, then keep clocking with EN=1.
    reset_dut();
    for (int i = 0; i < 55; i++) step(1'b1, 1'b0, 1'b0, 32'(4 * (i + 1)), 1'b0, 4'd0);
    chk("stop_done", bus.done, 1'b1);
    chk("stop_cycles", bus.cycle_count, 16'd50);
    chk("stop_count", bus.count, 5'd16);
    rd(4'd0);
    chk("stop_idx0", bus.rd_cycle, 16'd34);
    rd(4'd15);
    chk("stop_idx15", bus.rd_cycle, 16'd49);

    // Asynchronous reset mid-run, then a fresh capture.
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'(4 * (i + 1)), 1'b1, 4'd0);
    chk("pre_reset_count", bus.count, 5'd3);
    reset_dut();
    step(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 4'd0);
    rd(4'd0);
    chk("post_reset_cyc", bus.rd_cycle, 16'd0);
    chk("post_reset_pc", bus.rd_pc, 32'h100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
